carry_stage_m: RTL and testbench
================================

# carry_stage_M

Second counting stage placed directly downstream of `counter_N`. It consumes the upstream `carry_out_N` and `count_N` and counts carries modulo M. It produces a combined registered count and a chainable carry for a further stage. A small checker FSM flags any inconsistency between the upstream carry and the upstream count value; the flag is sticky until reset.

## Interface
- `N`, 6: modulus of upstream `counter_N`
- `M`, 10: modulus of this stage
- `LW`, 3: width of `count_in`
- `HW`, 4: width of `count_hi`, ≥ clog2(M)
- `TW`, 6: width of `total`, ≥ clog2(N*M)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  same enable that drives `counter_N`
- `carry_in`  in  1  connected to `carry_out_N`
- `count_in`  in  LW  connected to `count_N`
- `count_hi`  out  HW  carry count, 0..M-1
- `total`  out  TW  registered value `count_hi*N + count_in`
- `carry_out_M`  out  1  combinational carry to the next stage
- `fault`  out  1  sticky consistency error
- `state`  out  2  checker state: IDLE=0, RUN=1, FAULT=2

## Operation
- **Carry convention, shared with upstream:** `carry_in` is high during the cycle in which `count_in == N-1` and `enable == 1`. Upstream wraps on the following edge.
- **Counting:**
  - On an edge with `enable && carry_in`, `count_hi` increments.
  - When `count_hi == M-1`, that increment wraps it to 0.
  - With `enable == 0`, `count_hi` holds, whatever `carry_in` is.
- **Carry out:** `carry_out_M = enable && carry_in && (count_hi == M-1)`. It is combinational, so stages chain with no added latency.
- **Total:** `total <= count_hi*N + count_in` every cycle. Width is exactly TW and is never truncated, since N*M-1 fits in TW.
- **Watchdog counter `wd`:**
  - Width is clog2(N).
  - Cleared on an edge with `enable && carry_in`.
  - Increments on an edge with `enable && !carry_in`.
  - Holds when `enable == 0`.
- **Checker FSM:**
  - IDLE → RUN on the first cycle with `enable == 1`. No checks are made in IDLE.
  - RUN → FAULT at the edge ending any cycle with `enable == 1` that meets any of these conditions:
    - (a) `carry_in && count_in != N-1`
    - (b) `!carry_in && count_in == N-1`
    - (c) `count_in >= N`
    - (d) `!carry_in && wd == N-1`, meaning N enabled cycles have passed with no carry
  - In RUN, `carry_in == 1` while `enable == 0` is also condition (a).
  - FAULT is absorbing: only `reset` leaves it. `fault = (state == FAULT)`.
- **Counting in FAULT:** counting continues in FAULT. The checker only reports; it never blocks counting.

## Timing
- **Reset:** `reset` high at an edge sets `count_hi=0`, `total=0`, `wd=0`, `state=IDLE`, `fault=0`. `carry_out_M` is then 0, because `count_hi=0` and M>1.
- **Reset precedence:** reset overrides all other inputs. A reset in the middle of a run takes effect at the next edge, and no pending carry is kept.
- **Latency:**
  - `count_hi`: 1 cycle after the qualifying carry.
  - `total`: 1 cycle after the `count_hi`/`count_in` values it sums.
  - `fault`: 1 cycle after the offending input cycle.
  - `carry_out_M`: 0 cycles.
- **Simultaneous events:**
  - A carry and a fault condition in the same cycle: `count_hi` increments and the state goes to FAULT.
  - A carry on the cycle IDLE→RUN counts normally.

## Structure
- **Shared package `counter_pkg`:** checker state encodings (IDLE/RUN/FAULT) and default N/M constants, reused by `counter_N` benches.
- **Sub-module `carry_checker`:** the FSM plus `wd`. Inputs `clk`, `reset`, `enable`, `carry_in`, `count_in`. Outputs `state`, `fault`.
- **Top level:** `count_hi`, `total` and `carry_out_M` stay in the top module.

## Test plan
All scenarios use N=6, M=10, with a real `counter_N` driving the inputs unless stated.
- Reset held for 3 edges, `enable=0` → `count_hi=0`, `total=0`, `fault=0`, `state=0`. These values hold after reset drops while `enable` stays 0.
- `enable=1` for 60 cycles → `count_hi` steps 0..9 and back to 0. `carry_out_M` pulses exactly once, in the cycle with `count_hi=9`, `count_in=5`. `total` tracks 0..59 one cycle late; `fault=0` throughout.
- Drop `enable` for 5 cycles at `count_hi=3` → `count_hi`, `total` and `wd` hold, and no fault is raised.
- Bench-driven inputs, `enable=1`, `carry_in=1` with `count_in=3` → `state=2`, `fault=1` the next cycle. Both stay set through 20 more cycles and clear only on reset.
- Bench-driven `count_in` stuck at 2 with `carry_in=0` and `enable=1` → `fault=1` after the 6th enabled cycle in RUN. A separate run with `count_in=5`, `carry_in=0` → fault after 1 cycle.
- Reset asserted for 1 cycle during a run at `count_hi=4` with `carry_in=1` → next edge gives `count_hi=0`, `total=0`, `state=IDLE`; the carry is not counted.

Source files
------------

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
//
// Shared definitions for the counter_N / carry_stage_m counting chain:
//   - chk_state_t : encoding of the carry-consistency checker state
//                   (IDLE=0, RUN=1, FAULT=2); this encoding is visible on the
//                   `state` port, so it must not be reordered.
//   - N_DEFAULT / M_DEFAULT : default moduli of the upstream and this stage.
//   - width_for() : bit width needed to hold the values 0..count-1 (minimum 1).
// -----------------------------------------------------------------------------
package counter_pkg;

   localparam int N_DEFAULT = 6;
   localparam int M_DEFAULT = 10;

   typedef enum logic [1:0] {
      CHK_IDLE  = 2'd0,
      CHK_RUN   = 2'd1,
      CHK_FAULT = 2'd2
   } chk_state_t;

   // Width of a counter that runs 0..count-1. A modulus of 1 still needs one
   // bit so the counter does not collapse to a zero-width vector.
   function automatic int width_for(input int count);
      int w;
      w = $clog2(count);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage : counter_pkg

// File: rtl/carry_checker.sv
// -----------------------------------------------------------------------------
// carry_checker
//
// Watches the upstream counter_N carry/count pair and flags any inconsistency.
// Once a fault is seen the checker stays in FAULT until reset; it never
// influences counting.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous, active-high reset
//   enable    in   enable shared with counter_N
//   carry_in  in   upstream carry_out_N
//   count_in  in   upstream count_N (LW bits)
//   state     out  checker state (IDLE/RUN/FAULT), registered
//   fault     out  sticky error flag, registered, equals (state == FAULT)
// -----------------------------------------------------------------------------
module carry_checker
   import counter_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int LW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          carry_in,
   input  logic [LW-1:0] count_in,
   output chk_state_t    state,
   output logic          fault
);

   // Watchdog width: wd only has to reach N-1.
   localparam int WDW = width_for(N);

   localparam logic [LW-1:0]  LAST_CNT = LW'(N - 1);
   // One extra bit so count_in >= N works even when N == 2**LW.
   localparam logic [LW:0]    N_EXT    = (LW + 1)'(N);
   localparam logic [WDW-1:0] WD_LAST  = WDW'(N - 1);

   logic [WDW-1:0] wd;
   logic           violation;

   // Consistency conditions evaluated in the current cycle. With enable low
   // the upstream counter is frozen, so any carry at all is inconsistent.
   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no
      // path leaves it unassigned and no latch is inferred.
      violation = 1'b0;
      if (enable) begin
         violation = (carry_in  && (count_in != LAST_CNT))  // carry at wrong count
                  || (!carry_in && (count_in == LAST_CNT))  // missing carry
                  || ({1'b0, count_in} >= N_EXT)            // count out of range
                  || (!carry_in && (wd == WD_LAST));        // N cycles, no carry
      end else begin
         violation = carry_in;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state <= CHK_IDLE;
         fault <= 1'b0;
         wd    <= '0;
      end else begin
         // The watchdog starts from zero when the checker leaves IDLE, so the
         // first missing-carry window is a full N enabled cycles of RUN.
         if (enable && (state != CHK_IDLE)) begin
            if (carry_in) wd <= '0;
            else          wd <= wd + WDW'(1);
         end

         case (state)
            CHK_IDLE: begin
               if (enable) state <= CHK_RUN;
            end
            CHK_RUN: begin
               if (violation) begin
                  state <= CHK_FAULT;
                  fault <= 1'b1;
               end
            end
            CHK_FAULT: begin
               // Absorbing: only reset leaves FAULT.
            end
            default: begin
               // Unused encoding is itself an inconsistency.
               state <= CHK_FAULT;
               fault <= 1'b1;
            end
         endcase
      end
   end

endmodule : carry_checker

// File: rtl/carry_stage_m.sv
// -----------------------------------------------------------------------------
// carry_stage_m
//
// Second counting stage behind counter_N. Counts upstream carries modulo M,
// publishes a registered combined count total = count_hi*N + count_in, and
// produces a combinational carry so further stages chain with no latency.
// A carry_checker instance reports inconsistent upstream carry/count pairs.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   reset        in   synchronous, active-high reset
//   enable       in   enable shared with counter_N
//   carry_in     in   upstream carry_out_N
//   count_in     in   upstream count_N (LW bits)
//   count_hi     out  carry count 0..M-1 (HW bits), registered
//   total        out  registered count_hi*N + count_in (TW bits)
//   carry_out_M  out  combinational carry to the next stage
//   fault        out  sticky consistency error
//   state        out  checker state: IDLE=0, RUN=1, FAULT=2
// -----------------------------------------------------------------------------
module carry_stage_m
   import counter_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int M  = M_DEFAULT,
   parameter int LW = 3,
   parameter int HW = 4,
   parameter int TW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          carry_in,
   input  logic [LW-1:0] count_in,
   output logic [HW-1:0] count_hi,
   output logic [TW-1:0] total,
   output logic          carry_out_M,
   output logic          fault,
   output logic [1:0]    state
);

   localparam logic [HW-1:0] HI_LAST = HW'(M - 1);
   localparam logic [TW-1:0] N_T     = TW'(N);

   chk_state_t chk_state;
   logic       carry_qual;
   logic       hi_at_last;

   assign carry_qual  = enable && carry_in;
   assign hi_at_last  = (count_hi == HI_LAST);
   assign carry_out_M = carry_qual && hi_at_last;

   // High-order count and the combined total. Both are plain registers; the
   // checker result never gates counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_hi <= '0;
         total    <= '0;
      end else begin
         if (carry_qual) begin
            if (hi_at_last) count_hi <= '0;
            else            count_hi <= count_hi + HW'(1);
         end
         // TW holds N*M-1, so the sum is computed at full output width.
         total <= TW'(count_hi) * N_T + TW'(count_in);
      end
   end

   carry_checker #(
      .N  (N),
      .LW (LW)
   ) u_checker (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .carry_in (carry_in),
      .count_in (count_in),
      .state    (chk_state),
      .fault    (fault)
   );

   assign state = chk_state;

endmodule : carry_stage_m

// File: tb/tb_carry_stage_m.sv
// -----------------------------------------------------------------------------
// tb_carry_stage_m
//
// Directed bench for carry_stage_m with N=6, M=10. An upstream counter_N is
// emulated by deriving count_in/carry_in from a running cycle index; the
// remaining scenarios drive the upstream inputs directly.
// -----------------------------------------------------------------------------
module tb_carry_stage_m;

   localparam int N  = 6;
   localparam int M  = 10;
   localparam int LW = 3;
   localparam int HW = 4;
   localparam int TW = 6;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          carry_in;
   logic [LW-1:0] count_in;
   logic [HW-1:0] count_hi;
   logic [TW-1:0] total;
   logic          carry_out_M;
   logic          fault;
   logic [1:0]    state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   carry_stage_m #(
      .N  (N),
      .M  (M),
      .LW (LW),
      .HW (HW),
      .TW (TW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .carry_in    (carry_in),
      .count_in    (count_in),
      .count_hi    (count_hi),
      .total       (total),
      .carry_out_M (carry_out_M),
      .fault       (fault),
      .state       (state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic drive(input bit rst, input bit en, input bit ci, input int cin);
      reset    = rst;
      enable   = en;
      carry_in = ci;
      count_in = LW'(cin);
   endtask

   // Advance one edge and sample 1 time unit later, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 0);
      tick();
      check("reset_state", state, 0);
      check("reset_fault", fault, 0);
      drive(0, 0, 0, 0);
   endtask

   // Upstream counter_N emulation: cycle i presents count_in = i%N and a carry
   // when it equals N-1. Expected values are closed forms of the cycle index.
   task automatic run_counter(input int from, input int to);
      for (int i = from; i <= to; i++) begin
         int up;
         up = i % N;
         drive(0, 1, (up == N - 1), up);
         #1;
         check($sformatf("carry_out_M[%0d]", i), carry_out_M, (i % (N * M)) == (N * M - 1));
         tick();
         check($sformatf("count_hi[%0d]", i), count_hi, ((i + 1) / N) % M);
         check($sformatf("total[%0d]", i), total, i % (N * M));
         check($sformatf("fault[%0d]", i), fault, 0);
      end
   endtask

   initial begin
      // Reset held for 3 edges with enable low.
      drive(1, 0, 0, 0);
      repeat (3) tick();
      check("rst_count_hi", count_hi, 0);
      check("rst_total", total, 0);
      check("rst_fault", fault, 0);
      check("rst_state", state, 0);
      check("rst_carry_out", carry_out_M, 0);

      // Values hold after reset drops while enable stays low.
      drive(0, 0, 0, 0);
      repeat (3) begin
         tick();
         check("idle_count_hi", count_hi, 0);
         check("idle_total", total, 0);
         check("idle_state", state, 0);
      end

      // 60 enabled cycles: full wrap of count_hi, single carry_out_M pulse.
      run_counter(0, 59);
      check("wrap_state", state, 1);

      // Continue to count_hi=3, upstream count mid-way at 2.
      run_counter(60, 79);
      check("pre_hold_count_hi", count_hi, 3);

      // Enable low for 5 cycles: count_hi holds, total settles to 3*6+2=20.
      drive(0, 0, 0, 2);
      repeat (5) begin
         tick();
         check("hold_count_hi", count_hi, 3);
         check("hold_total", total, 20);
         check("hold_state", state, 1);
         check("hold_fault", fault, 0);
      end

      // Resume; a watchdog that had advanced during the hold would misfire.
      run_counter(80, 88);
      check("resume_state", state, 1);

      // Reset during a qualifying carry at count_hi=4: the carry is dropped.
      drive(1, 1, 1, 5);
      #1;
      check("pre_reset_carry_out", carry_out_M, 0);
      tick();
      check("midrst_count_hi", count_hi, 0);
      check("midrst_total", total, 0);
      check("midrst_state", state, 0);
      check("midrst_fault", fault, 0);

      // Carry at the wrong count: FAULT next cycle, counting continues.
      drive(0, 1, 0, 0);
      tick();
      check("a_run_state", state, 1);
      drive(0, 1, 1, 3);
      tick();
      check("a_state", state, 2);
      check("a_fault", fault, 1);
      check("a_count_hi", count_hi, 1);
      check("a_total", total, 3);
      drive(0, 1, 1, 5);
      repeat (20) begin
         tick();
         check("a_sticky_state", state, 2);
         check("a_sticky_fault", fault, 1);
      end
      // 1 + 20 carries mod 10; total uses count_hi before the last carry (0).
      check("a_count_hi_after", count_hi, 1);
      check("a_total_after", total, 5);
      drive(1, 0, 0, 0);
      tick();
      check("a_clear_state", state, 0);
      check("a_clear_fault", fault, 0);
      check("a_clear_count_hi", count_hi, 0);

      // Stuck count_in=2 without carry: watchdog fires on the 6th RUN cycle.
      drive(0, 1, 0, 2);
      tick();
      check("wd_enter_run", state, 1);
      for (int k = 1; k <= N; k++) begin
         tick();
         check($sformatf("wd_state[%0d]", k), state, (k == N) ? 2 : 1);
         check($sformatf("wd_fault[%0d]", k), fault, (k == N) ? 1 : 0);
      end
      check("wd_count_hi", count_hi, 0);

      // Missing carry at count_in=N-1: fault after 1 cycle.
      do_reset();
      drive(0, 1, 0, 0);
      tick();
      drive(0, 1, 0, 5);
      tick();
      check("b_state", state, 2);
      check("b_fault", fault, 1);

      // Out-of-range count (count_in = N).
      do_reset();
      drive(0, 1, 0, 0);
      tick();
      drive(0, 1, 0, 6);
      tick();
      check("c_state", state, 2);

      // Carry while enable low in RUN; count_hi must not move.
      do_reset();
      drive(0, 1, 0, 0);
      tick();
      drive(0, 0, 1, 5);
      #1;
      check("dis_carry_out", carry_out_M, 0);
      tick();
      check("dis_state", state, 2);
      check("dis_count_hi", count_hi, 0);

      // Carry on the IDLE->RUN cycle counts; no check is made in IDLE.
      do_reset();
      drive(0, 1, 1, 3);
      tick();
      check("idle_carry_state", state, 1);
      check("idle_carry_fault", fault, 0);
      check("idle_carry_count_hi", count_hi, 1);
      check("idle_carry_total", total, 3);

      drive(0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_carry_stage_m
